crc32_frame_ctrl: RTL and testbench

Frame-level sequencer for the `crc32` slicing core. It accepts an AXI-Stream frame, drives the core one 32-bit beat per cycle, and owns the CRC state feedback register. It re-seeds that register between frames and presents the final FCS, byte count and error status on a ready/valid result port. It sits between the MAC TX/RX byte-lane datapath and the FCS insert/strip logic.

---
 rtl/crc_pkg.sv | 28 ++
 rtl/crc32.sv | 30 +++
 rtl/crc32_frame_ctrl.sv | 118 +++++++++++
 tb/tb_crc32_frame_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared CRC-32 types, constants and the reflected byte-update helper
package crc_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int CRC_WIDTH  = 32;
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  typedef logic [CRC_WIDTH-1:0] crc_word_t;

  localparam crc_word_t CRC_INIT            = 32'hFFFFFFFF;
  localparam crc_word_t CRC_RESIDUE_DEFAULT = 32'h2144DF1C;
  localparam crc_word_t CRC_POLY_REFL       = 32'hEDB88320;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2
  } crc_ctrl_state_t;

  // LSB-first (reflected) update of the running register by one byte
  function automatic crc_word_t crc_byte_update(input crc_word_t crc, input logic [7:0] data);
    crc_word_t r;
    r = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY_REFL) : (r >> 1);
    end
    return r;
  endfunction
endpackage

// File: rtl/crc32.sv
// rtl/crc32.sv - combinational CRC-32 core absorbing up to four byte lanes per call
import crc_pkg::*;

module crc32 (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [KEEP_WIDTH-1:0] i_data_valid,
  input  crc_word_t             i_crc_state,
  output crc_word_t             o_crc_state,
  output crc_word_t             o_crc
);
  crc_word_t c;

  // Clock and reset are part of the core's interface but the datapath is purely combinational
  logic unused_clk_rst;
  assign unused_clk_rst = i_clk ^ i_reset_n;

  // Lane 0 is the first byte on the wire; lanes with a clear valid bit are skipped
  always_comb begin
    c = i_crc_state;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      if (i_data_valid[i]) begin
        c = crc_byte_update(c, i_data[8*i +: 8]);
      end
    end
    o_crc_state = c;
    o_crc       = ~c;
  end
endmodule

// File: rtl/crc32_frame_ctrl.sv
// rtl/crc32_frame_ctrl.sv - frame sequencer around crc32; CRC_CHECK_EN adds the o_fcs_ok residue check
import crc_pkg::*;

module crc32_frame_ctrl #(
  parameter int                   DATA_WIDTH = 32,
  parameter int                   CRC_WIDTH  = 32,
  parameter logic [CRC_WIDTH-1:0] RESIDUE    = 32'h2144DF1C
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [3:0]            s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [CRC_WIDTH-1:0]  o_fcs,
  output logic [15:0]           o_frame_len,
  output logic                  o_keep_err,
`ifdef CRC_CHECK_EN
  output logic                  o_fcs_ok,
`endif
  output logic                  o_fcs_valid,
  input  logic                  i_fcs_ready
);
  crc_ctrl_state_t state_q, state_d;
  crc_word_t       crc_q, core_state, core_crc;
  logic [15:0]     len_q, len_base, len_sum;
  logic [16:0]     len_wide;
  logic [2:0]      beat_bytes;
  logic            err_q, beat_err, err_sum;
  logic            accept;

  assign s_axis_tready = (state_q != HOLD);
  assign o_fcs_valid   = (state_q == HOLD);
  assign accept        = s_axis_tvalid && s_axis_tready;

  crc32 u_crc32 (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_data       (s_axis_tdata),
    .i_data_valid (accept ? s_axis_tkeep : 4'h0),
    .i_crc_state  (crc_q),
    .o_crc_state  (core_state),
    .o_crc        (core_crc)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = s_axis_tlast ? HOLD : ACTIVE;
      ACTIVE:  if (accept && s_axis_tlast) state_d = HOLD;
      HOLD:    if (i_fcs_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Running totals restart from zero on the first beat of a frame
  always_comb begin
    beat_bytes = 3'($countones(s_axis_tkeep));
    len_base   = (state_q == IDLE) ? 16'h0 : len_q;
    len_wide   = {1'b0, len_base} + {14'h0, beat_bytes};
    len_sum    = len_wide[16] ? 16'hFFFF : len_wide[15:0];
    if (s_axis_tlast) begin
      beat_err = !(s_axis_tkeep inside {4'h1, 4'h3, 4'h7, 4'hF});
    end else begin
      beat_err = (s_axis_tkeep != 4'hF);
    end
    err_sum = ((state_q == IDLE) ? 1'b0 : err_q) | beat_err;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      crc_q       <= CRC_INIT;
      len_q       <= 16'h0;
      err_q       <= 1'b0;
      o_fcs       <= '0;
      o_frame_len <= 16'h0;
      o_keep_err  <= 1'b0;
    end else if (accept) begin
      if (s_axis_tlast) begin
        crc_q       <= CRC_INIT;
        len_q       <= 16'h0;
        err_q       <= 1'b0;
        o_fcs       <= core_crc;
        o_frame_len <= len_sum;
        o_keep_err  <= err_sum;
      end else begin
        crc_q <= core_state;
        len_q <= len_sum;
        err_q <= err_sum;
      end
    end else if (state_q == IDLE) begin
      len_q <= 16'h0;
      err_q <= 1'b0;
    end
  end

`ifdef CRC_CHECK_EN
  // Over data plus its own FCS, a good frame leaves the fixed residue in o_crc
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_fcs_ok <= 1'b0;
    end else if (accept && s_axis_tlast) begin
      o_fcs_ok <= (core_crc == RESIDUE);
    end
  end
`else
  localparam logic [CRC_WIDTH-1:0] unused_residue = RESIDUE;
`endif
endmodule

// File: tb/tb_crc32_frame_ctrl.sv
// tb/tb_crc32_frame_ctrl.sv - directed and random frames checked against a table-driven CRC-32 model
module tb_crc32_frame_ctrl;
  logic        i_clk;
  logic        i_reset_n;
  logic [31:0] s_axis_tdata;
  logic [3:0]  s_axis_tkeep;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [31:0] o_fcs;
  logic [15:0] o_frame_len;
  logic        o_keep_err;
  logic        o_fcs_ok;
  logic        o_fcs_valid;
  logic        i_fcs_ready;

  int checks = 0;
  int errors = 0;

  logic [31:0] t0 [256];
  logic [31:0] t1 [256];
  logic [31:0] t2 [256];
  logic [31:0] t3 [256];
  logic [7:0]  fq [$];

  crc32_frame_ctrl dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .o_fcs         (o_fcs),
    .o_frame_len   (o_frame_len),
    .o_keep_err    (o_keep_err),
`ifdef CRC_CHECK_EN
    .o_fcs_ok      (o_fcs_ok),
`endif
    .o_fcs_valid   (o_fcs_valid),
    .i_fcs_ready   (i_fcs_ready)
  );

`ifndef CRC_CHECK_EN
  assign o_fcs_ok = 1'b0;
`endif

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic build_tables();
    logic [31:0] c;
    for (int i = 0; i < 256; i++) begin
      c = 32'(i);
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      t0[i] = c;
    end
    for (int i = 0; i < 256; i++) begin
      t1[i] = (t0[i] >> 8) ^ t0[t0[i][7:0]];
      t2[i] = (t1[i] >> 8) ^ t0[t1[i][7:0]];
      t3[i] = (t2[i] >> 8) ^ t0[t2[i][7:0]];
    end
  endtask

  // Slicing-by-4 over whole words, table-per-byte over the tail
  function automatic logic [31:0] model_crc(input logic [7:0] b [$]);
    logic [31:0] c;
    int i;
    c = 32'hFFFFFFFF;
    i = 0;
    while (i + 4 <= b.size()) begin
      c = c ^ {b[i+3], b[i+2], b[i+1], b[i]};
      c = t3[c[7:0]] ^ t2[c[15:8]] ^ t1[c[23:16]] ^ t0[c[31:24]];
      i += 4;
    end
    while (i < b.size()) begin
      c = (c >> 8) ^ t0[c[7:0] ^ b[i]];
      i++;
    end
    return ~c;
  endfunction

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                           input int gap, output int waited);
    waited = 0;
    repeat (gap) @(posedge i_clk);
    #1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    @(negedge i_clk);
    while (!s_axis_tready && waited < 20) begin
      @(negedge i_clk);
      waited++;
    end
    if (!s_axis_tready) check("tready_timeout", 32'(s_axis_tready), 32'd1);
    @(posedge i_clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_frame(input int gap_pct, output int first_wait);
    int n, i, cnt, gap, w;
    logic [31:0] d;
    logic [3:0]  k;
    n = fq.size();
    i = 0;
    first_wait = 0;
    while (i < n) begin
      d   = $urandom;
      k   = 4'h0;
      cnt = (n - i > 4) ? 4 : n - i;
      for (int j = 0; j < cnt; j++) begin
        d[8*j +: 8] = fq[i+j];
        k[j] = 1'b1;
      end
      gap = (int'($urandom_range(99)) < gap_pct) ? int'($urandom_range(3, 1)) : 0;
      send_beat(d, k, (i + cnt == n), gap, w);
      if (i == 0) first_wait = w;
      i += cnt;
    end
  endtask

  task automatic expect_result(input string tag, input logic [31:0] efcs,
                               input logic [15:0] elen, input logic eerr);
    int n;
    n = 0;
    @(negedge i_clk);
    while (!o_fcs_valid && n < 5) begin
      @(negedge i_clk);
      n++;
    end
    check({tag, "_valid"}, 32'(o_fcs_valid), 32'd1);
    check({tag, "_fcs"}, o_fcs, efcs);
    check({tag, "_len"}, 32'(o_frame_len), 32'(elen));
    check({tag, "_keep_err"}, 32'(o_keep_err), 32'(eerr));
    if (i_fcs_ready) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic load_123();
    fq.delete();
    for (int i = 0; i < 9; i++) fq.push_back(8'h31 + 8'(i));
  endtask

  task automatic load_random(input int n);
    fq.delete();
    for (int i = 0; i < n; i++) fq.push_back(8'($urandom));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tready"}, 32'(s_axis_tready), 32'd1);
    check({tag, "_fcs"}, o_fcs, 32'h0);
    check({tag, "_len"}, 32'(o_frame_len), 32'h0);
    check({tag, "_keep_err"}, 32'(o_keep_err), 32'h0);
    check({tag, "_fcs_ok"}, 32'(o_fcs_ok), 32'h0);
    check({tag, "_valid"}, 32'(o_fcs_valid), 32'h0);
  endtask

  initial begin
    logic [7:0]  kq [$];
    logic [31:0] d, efcs;
    int w, n;

    i_reset_n     = 1'b0;
    s_axis_tdata  = 32'h0;
    s_axis_tkeep  = 4'h0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    i_fcs_ready   = 1'b1;
    build_tables();
    repeat (2) @(posedge i_clk);
    #1;
    check_reset_outputs("reset");
    i_reset_n = 1'b1;
    @(posedge i_clk);

    // Standard check string, three beats
    load_123();
    send_frame(0, w);
    expect_result("std", 32'hCBF43926, 16'd9, 1'b0);

`ifdef CRC_CHECK_EN
    load_123();
    fq.push_back(8'h26); fq.push_back(8'h39); fq.push_back(8'hF4); fq.push_back(8'hCB);
    send_frame(0, w);
    expect_result("rx_good", model_crc(fq), 16'd13, 1'b0);
    check("rx_good_ok", 32'(o_fcs_ok), 32'd1);
    fq[4] = fq[4] ^ 8'h10;
    send_frame(0, w);
    expect_result("rx_bad", model_crc(fq), 16'd13, 1'b0);
    check("rx_bad_ok", 32'(o_fcs_ok), 32'd0);
`endif

    // Result held with i_fcs_ready low for five cycles
    load_random(10);
    efcs = model_crc(fq);
    i_fcs_ready = 1'b0;
    send_frame(0, w);
    for (int c = 0; c < 5; c++) begin
      @(negedge i_clk);
      check("hold_tready", 32'(s_axis_tready), 32'd0);
      check("hold_valid", 32'(o_fcs_valid), 32'd1);
      check("hold_fcs", o_fcs, efcs);
      check("hold_len", 32'(o_frame_len), 32'd10);
    end
    i_fcs_ready = 1'b1;
    @(posedge i_clk);
    load_random(6);
    send_frame(0, w);
    check("after_hold_first_wait", 32'(w), 32'd0);
    expect_result("after_hold", model_crc(fq), 16'd6, 1'b0);

    // Short non-last beat flags a keep error; lanes with keep set still feed the CRC
    kq.delete();
    d = $urandom;
    send_beat(d, 4'h3, 1'b0, 0, w);
    kq.push_back(d[7:0]); kq.push_back(d[15:8]);
    d = $urandom;
    send_beat(d, 4'hF, 1'b0, 0, w);
    for (int j = 0; j < 4; j++) kq.push_back(d[8*j +: 8]);
    d = $urandom;
    send_beat(d, 4'h1, 1'b1, 0, w);
    kq.push_back(d[7:0]);
    expect_result("keep_mid", model_crc(kq), 16'd7, 1'b1);

    load_random(8);
    send_frame(0, w);
    expect_result("keep_clean", model_crc(fq), 16'd8, 1'b0);

    // Non-contiguous keep on a single-beat frame
    kq.delete();
    d = $urandom;
    send_beat(d, 4'h5, 1'b1, 0, w);
    kq.push_back(d[7:0]); kq.push_back(d[23:16]);
    expect_result("keep_last", model_crc(kq), 16'd2, 1'b1);

    // Back-to-back random frames with random tvalid gaps
    for (int f = 0; f < 8; f++) begin
      n = int'($urandom_range(1500, 4));
      load_random(n);
      send_frame(25, w);
      expect_result($sformatf("rand%0d", f), model_crc(fq), 16'(n), 1'b0);
    end

    // Asynchronous reset in the middle of a frame
    d = $urandom;
    send_beat(d, 4'hF, 1'b0, 0, w);
    d = $urandom;
    send_beat(d, 4'hF, 1'b0, 0, w);
    #2;
    i_reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    @(posedge i_clk);
    load_123();
    send_frame(0, w);
    expect_result("post_reset", 32'hCBF43926, 16'd9, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
